hazard_interlock: RTL
=====================

Name: hazard_interlock

Overview:
- Pipeline interlock unit at the ID stage (stage 2) of the 5-stage MIPS pipeline. It is the stall side of the EX-stage forwarding path.
- Keeps a shadow copy of the destination-register info for stages 3/4/5.
- Detects hazards that forwarding cannot cover: load-use, data-memory wait, and the optional regfile write/read collision.
- Drives PC / IF-ID write enables, the ID/EX bubble and a global pipeline hold. Counts stall cycles for performance reporting.

Parameters:
- RF_BYPASS, 1: 1 = regfile is write-through, so a stage-5 write never stalls ID; 0 = stall ID one cycle on a stage-5 dest collision.
- CNT_W, 16: width of the stall counter.

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous active-low reset
- valid_2  in  1  ID holds a real instruction
- rs_2  in  5  ID source register A
- rt_2  in  5  ID source register B
- use_rs_2  in  1  ID instruction reads rs
- use_rt_2  in  1  ID instruction reads rt
- rd_2  in  5  ID destination register (already muxed rt/rd)
- RegWr_2  in  1  ID instruction writes the regfile
- MemtoReg_2  in  1  ID instruction is a load
- flush_2  in  1  branch/jump resolved taken; squash the ID instruction
- mem_ready_4  in  1  data memory completes the stage-4 access this cycle
- PCWr  out  1  PC write enable
- IFIDWr  out  1  IF/ID register write enable
- bubble_3  out  1  load zero control into ID/EX
- pipe_hold  out  1  freeze ID/EX, EX/MEM, MEM/WB
- stall_cnt  out  CNT_W  saturating count of cycles with PCWr=0

Behaviour:
- State: three shadow entries e3, e4, e5, each {v, wr, ld, rd[4:0]}, plus stall_cnt.
- Reset (async, rst_n=0): all entries v=0, stall_cnt=0. Outputs after reset: PCWr=1, IFIDWr=1, bubble_3=0, pipe_hold=0.
- src_hit(e) = e.v & e.wr & (e.rd!=0) & ((use_rs_2 & rs_2==e.rd) | (use_rt_2 & rt_2==e.rd)), qualified with valid_2.
- Condition terms, combinational from the current state:
  - mem_wait = e4.v & e4.ld & !mem_ready_4.
  - lu_stall = src_hit(e3) & e3.ld.
  - wb_stall = (RF_BYPASS==0) & src_hit(e5).
- Output rules, first matching rule wins:
  1. mem_wait: pipe_hold=1, PCWr=0, IFIDWr=0, bubble_3=0.
  2. lu_stall | wb_stall: PCWr=0, IFIDWr=0, bubble_3=1, pipe_hold=0.
  3. otherwise: PCWr=1, IFIDWr=1, bubble_3=flush_2, pipe_hold=0.
- Update on rising clk:
  - mem_wait: e3/e4/e5 hold.
  - Otherwise: e5<=e4, e4<=e3.
  - e3 becomes invalid if any of lu_stall, wb_stall, flush_2 or !valid_2 holds. Otherwise e3<={1, RegWr_2, MemtoReg_2, rd_2}.
- flush_2 concurrent with lu_stall: stall wins, ID is held, and the flush is re-presented by its source next cycle. Same for flush_2 during mem_wait.
- stall_cnt increments in every cycle with PCWr=0 and saturates at all-ones; no wrap.
- Load-use latency: exactly 1 stall cycle when mem_ready_4 is asserted on first access. Each cycle with mem_ready_4=0 adds 1 hold cycle.
- A load-use hazard detected during mem_wait is re-evaluated after the hold releases; the entries are unchanged, so the stall follows.
- rd=0 never causes a hazard.
- Reset asserted mid-stall clears all entries. The first cycle after release has no stall.

Decomposition:
- Shared package pipe_pkg:
  - Stage-entry struct {v, wr, ld, rd}.
  - BUBBLE entry constant (all zeros).
  - REG_ZERO=5'd0.
  - Stage index constants ST_ID=2, ST_EX=3, ST_MEM=4, ST_WB=5.
- One sub-module, hazard_hit: combinational src_hit for one entry, instantiated for e3 and e5.

Test Plan:
- Load-use: lw $8 in ID then add $9,$8,$1 (use_rs_2=1, rs_2=8) with mem_ready_4=1 -> exactly one cycle of PCWr=0/IFIDWr=0/bubble_3=1; stall_cnt 0->1; the next cycle passes.
- Memory wait: lw reaches stage 4 with mem_ready_4 low for 3 cycles -> pipe_hold=1 and PCWr=0 for 3 cycles; entries unchanged; stall_cnt +3.
- No false stall:
  - add $0 writing, then a reader of $0 -> no stall.
  - lw $8 followed by sw reading only $9 -> no stall.
  - lw $8 two instructions ahead -> no stall (forwarding covers it).
- Flush: flush_2=1 with no hazard -> bubble_3=1, PCWr=1; e3 invalid next cycle.
- RF_BYPASS=0: writer of $5 in stage 5 while ID reads rt=$5 -> one stall cycle. The same stimulus with RF_BYPASS=1 -> none.
- Reset during a load-use stall (rst_n low mid-cycle) -> outputs immediately PCWr=1, bubble_3=0, stall_cnt=0.

Source files
------------

// File: rtl/hazard_interlock_pkg.sv
// Shared pipeline definitions: stage-entry layout, bubble constant and stage indices.
package pipe_pkg;

  typedef struct packed {
    logic       v;
    logic       wr;
    logic       ld;
    logic [4:0] rd;
  } stage_entry_t;

  localparam stage_entry_t BUBBLE   = '0;
  localparam logic [4:0]   REG_ZERO = 5'd0;

  localparam int ST_ID  = 2;
  localparam int ST_EX  = 3;
  localparam int ST_MEM = 4;
  localparam int ST_WB  = 5;

endpackage

// File: rtl/hazard_interlock_hit.sv
// Source-operand match of the ID instruction against one downstream stage entry.
module hazard_hit
  import pipe_pkg::*;
(
  input  stage_entry_t i_entry,
  input  logic         i_valid,
  input  logic [4:0]   i_rs,
  input  logic [4:0]   i_rt,
  input  logic         i_use_rs,
  input  logic         i_use_rt,
  output logic         o_hit
);

  logic w_rs_match;
  logic w_rt_match;

  assign w_rs_match = i_use_rs && (i_rs == i_entry.rd);
  assign w_rt_match = i_use_rt && (i_rt == i_entry.rd);

  // $0 is hard-wired, so a write to it can never create a dependency.
  assign o_hit = i_valid && i_entry.v && i_entry.wr && (i_entry.rd != REG_ZERO) &&
                 (w_rs_match || w_rt_match);

endmodule

// File: rtl/hazard_interlock.sv
// ID-stage interlock: shadows dest info of stages 3..5 and stalls on hazards forwarding cannot cover.
module hazard_interlock
  import pipe_pkg::*;
#(
  parameter int RF_BYPASS = 1,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_2,
  input  logic [4:0]       rs_2,
  input  logic [4:0]       rt_2,
  input  logic             use_rs_2,
  input  logic             use_rt_2,
  input  logic [4:0]       rd_2,
  input  logic             RegWr_2,
  input  logic             MemtoReg_2,
  input  logic             flush_2,
  input  logic             mem_ready_4,
  output logic             PCWr,
  output logic             IFIDWr,
  output logic             bubble_3,
  output logic             pipe_hold,
  output logic [CNT_W-1:0] stall_cnt
);

  stage_entry_t     r_e3, r_e4, r_e5;
  logic [CNT_W-1:0] r_stall_cnt;

  logic w_hit3, w_hit5;
  logic w_mem_wait, w_lu_stall, w_wb_stall, w_kill_e3;

  hazard_hit u_hit_ex (
    .i_entry (r_e3),
    .i_valid (valid_2),
    .i_rs    (rs_2),
    .i_rt    (rt_2),
    .i_use_rs(use_rs_2),
    .i_use_rt(use_rt_2),
    .o_hit   (w_hit3)
  );

  hazard_hit u_hit_wb (
    .i_entry (r_e5),
    .i_valid (valid_2),
    .i_rs    (rs_2),
    .i_rt    (rt_2),
    .i_use_rs(use_rs_2),
    .i_use_rt(use_rt_2),
    .o_hit   (w_hit5)
  );

  assign w_mem_wait = r_e4.v && r_e4.ld && !mem_ready_4;
  assign w_lu_stall = w_hit3 && r_e3.ld;
  assign w_wb_stall = (RF_BYPASS == 0) && w_hit5;
  // A squashed, stalled or empty ID slot enters EX as a bubble.
  assign w_kill_e3  = w_lu_stall || w_wb_stall || flush_2 || !valid_2;

  // Memory wait outranks load-use: the whole back end is frozen, so ID just waits.
  always_comb begin
    // NOTE: every output gets a default first so no path through the block infers a latch.
    PCWr      = 1'b1;
    IFIDWr    = 1'b1;
    bubble_3  = flush_2;
    pipe_hold = 1'b0;
    if (w_mem_wait) begin
      PCWr      = 1'b0;
      IFIDWr    = 1'b0;
      bubble_3  = 1'b0;
      pipe_hold = 1'b1;
    end else if (w_lu_stall || w_wb_stall) begin
      PCWr      = 1'b0;
      IFIDWr    = 1'b0;
      bubble_3  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_e3 <= BUBBLE;
      r_e4 <= BUBBLE;
      r_e5 <= BUBBLE;
    end else if (!w_mem_wait) begin
      // NOTE: non-blocking assignments let the shift read the pre-edge values of every entry.
      r_e5 <= r_e4;
      r_e4 <= r_e3;
      r_e3 <= w_kill_e3 ? BUBBLE
                        : '{v: 1'b1, wr: RegWr_2, ld: MemtoReg_2, rd: rd_2};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (!PCWr && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign stall_cnt = r_stall_cnt;

endmodule
